// File: rtl/stopwatch_timer.sv
// ---------------------------------------------------------------------------
// stopwatch_timer
//
// Stopwatch core. A prescaler divides the system clock into a tick every
// DIVIDER cycles. Each tick advances an mm:ss.cc time held in six BCD digits.
// A small control FSM provides start/stop, lap-freeze and clear, and a sticky
// flag records a wrap past 59:59.99.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   : the LAP state, the snapshot registers and lap_active are built.
//   undefined : lap is ignored, lap_active is tied low and the digit outputs
//               always show the live time.
//
// Parameters
//   DIVIDER        clock cycles per tick (>= 2)
//   COUNTER_WIDTH  prescaler width, 2**COUNTER_WIDTH >= DIVIDER
//
// Ports
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   start_stop     one-cycle pulse, toggles run/stop
//   lap            one-cycle pulse, freezes/releases the display
//   clear          one-cycle pulse, returns to IDLE with zero time
//   min_higher .. ms_lower   displayed BCD digits
//   running        high while counting (RUNNING or LAP)
//   lap_active     high in LAP
//   overflow       sticky, set when the time wraps past 59:59.99
// ---------------------------------------------------------------------------
module stopwatch_timer #(
    parameter int DIVIDER       = 500000,
    parameter int COUNTER_WIDTH = 19
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] min_higher,
    output logic [3:0] min_lower,
    output logic [3:0] s_higher,
    output logic [3:0] s_lower,
    output logic [3:0] ms_higher,
    output logic [3:0] ms_lower,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    // Bit 0 of the state encoding means "counting". This lets running come
    // straight from a flop.
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_STOPPED = 2'b10;
`ifdef STOPWATCH_LAP_EN
    localparam logic [1:0] ST_LAP     = 2'b11;
`endif

    localparam logic [COUNTER_WIDTH-1:0] PRESCALE_MAX = COUNTER_WIDTH'(DIVIDER - 1);

    logic [1:0]               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] prescaler_q, prescaler_d;
    // Live time packed as {min_h, min_l, s_h, s_l, ms_h, ms_l}.
    logic [23:0]              live_q, live_d;
    logic                     overflow_q, overflow_d;
    logic [23:0]              live_inc;
    logic                     wrap;
    logic                     counting;
    logic                     tick;
    logic [23:0]              display;

    assign counting = state_q[0];
    assign tick     = counting && (prescaler_q == PRESCALE_MAX);

    // Control FSM. clear beats start_stop, and start_stop beats lap. A lap
    // pulse that arrives together with start_stop is therefore dropped.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE:    state_d = ST_RUNNING;
                ST_RUNNING: state_d = ST_STOPPED;
                ST_STOPPED: state_d = ST_RUNNING;
                default:    state_d = ST_STOPPED;
            endcase
`ifdef STOPWATCH_LAP_EN
        end else if (lap) begin
            if (state_q == ST_RUNNING) begin
                state_d = ST_LAP;
            end else if (state_q == ST_LAP) begin
                state_d = ST_RUNNING;
            end
`endif
        end
    end

    // The prescaler holds while stopped. A resume therefore finishes the
    // partial tick that was in progress, and no cycles are lost or gained.
    always_comb begin
        prescaler_d = prescaler_q;
        if (clear) begin
            prescaler_d = '0;
        end else if (tick) begin
            prescaler_d = '0;
        end else if (counting) begin
            prescaler_d = prescaler_q + COUNTER_WIDTH'(1);
        end
    end

    // Mixed-radix increment. A digit carries only when it is at its limit.
    // The >= compare keeps the counter self-correcting.
    always_comb begin
        live_inc = live_q;
        wrap     = 1'b0;
        if (live_q[3:0] >= 4'd9) begin
            live_inc[3:0] = 4'd0;
            if (live_q[7:4] >= 4'd9) begin
                live_inc[7:4] = 4'd0;
                if (live_q[11:8] >= 4'd9) begin
                    live_inc[11:8] = 4'd0;
                    if (live_q[15:12] >= 4'd5) begin
                        live_inc[15:12] = 4'd0;
                        if (live_q[19:16] >= 4'd9) begin
                            live_inc[19:16] = 4'd0;
                            if (live_q[23:20] >= 4'd5) begin
                                live_inc[23:20] = 4'd0;
                                wrap            = 1'b1;
                            end else begin
                                live_inc[23:20] = live_q[23:20] + 4'd1;
                            end
                        end else begin
                            live_inc[19:16] = live_q[19:16] + 4'd1;
                        end
                    end else begin
                        live_inc[15:12] = live_q[15:12] + 4'd1;
                    end
                end else begin
                    live_inc[11:8] = live_q[11:8] + 4'd1;
                end
            end else begin
                live_inc[7:4] = live_q[7:4] + 4'd1;
            end
        end else begin
            live_inc[3:0] = live_q[3:0] + 4'd1;
        end
    end

    always_comb begin
        live_d     = live_q;
        overflow_d = overflow_q;
        if (clear) begin
            live_d     = '0;
            overflow_d = 1'b0;
        end else if (tick) begin
            live_d = live_inc;
            if (wrap) begin
                overflow_d = 1'b1;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [23:0] snap_q, snap_d;

    // The snapshot is taken from live_q, which is the value before any tick
    // on the same edge.
    always_comb begin
        snap_d = snap_q;
        if (clear) begin
            snap_d = '0;
        end else if ((state_q == ST_RUNNING) && (state_d == ST_LAP)) begin
            snap_d = live_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign lap_active = (state_q == ST_LAP);
    assign display    = lap_active ? snap_q : live_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_active = 1'b0;
    assign display    = live_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            prescaler_q <= '0;
            live_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            live_q      <= live_d;
            overflow_q  <= overflow_d;
        end
    end

    assign running    = counting;
    assign overflow   = overflow_q;
    assign min_higher = display[23:20];
    assign min_lower  = display[19:16];
    assign s_higher   = display[15:12];
    assign s_lower    = display[11:8];
    assign ms_higher  = display[7:4];
    assign ms_lower   = display[3:0];

endmodule

// File: doc/stopwatch_timer.md
# stopwatch_timer

Parametrised stopwatch core: divides the board clock into a 10 ms tick and keeps an mm:ss.cc time in six BCD digits with start/stop, lap-freeze and clear controls. It generalises the fixed free-running stopwatch counter with a configurable prescaler, correct BCD wrap limits, a control state machine and an overflow flag. It sits between the button conditioning logic, which supplies one-cycle pulses, and the per-digit `ssd` seven-segment decoders.

## Interface
- `DIVIDER`, 500000: clock cycles per tick (10 ms at 50 MHz); legal range ≥ 2.
- `COUNTER_WIDTH`, 19: prescaler width; must satisfy 2^COUNTER_WIDTH ≥ DIVIDER.
- `clock`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_stop`  in  1  one-cycle pulse; toggles run/stop.
- `lap`  in  1  one-cycle pulse; freezes or releases the display.
- `clear`  in  1  one-cycle pulse; zeroes the time.
- `min_higher`, `min_lower`, `s_higher`, `s_lower`, `ms_higher`, `ms_lower`  out  4 each  displayed BCD digits, 0–9.
- `running`  out  1  high in RUNNING and LAP.
- `lap_active`  out  1  high in LAP.
- `overflow`  out  1  sticky; set on wrap past 59:59.99.

## Operation
- States: IDLE, RUNNING, STOPPED, LAP.
- While `reset_n`=0: state is IDLE; prescaler, live digits, snapshot digits and `overflow` are all 0.
- Transitions, evaluated at each rising edge:
  - IDLE, `start_stop` → RUNNING.
  - RUNNING, `start_stop` → STOPPED.
  - RUNNING, `lap` → LAP; the current live digits are copied into the snapshot.
  - LAP, `lap` → RUNNING.
  - LAP, `start_stop` → STOPPED.
  - STOPPED, `start_stop` → RUNNING.
  - `lap` is ignored in IDLE and STOPPED.
- Priority: `clear` > `start_stop` > `lap`.
  - `clear` in any state → IDLE. Prescaler, live digits, snapshot and `overflow` go to 0.
  - If `start_stop` and `lap` arrive together, `lap` is ignored.
- Prescaler: advances only in RUNNING and LAP. At the value DIVIDER−1 it returns to 0 and issues a tick.
  - In STOPPED the prescaler holds its value, so resuming keeps the partial tick.
- Tick increment chain, mixed radix:
  - `ms_lower` counts 0–9, then `ms_higher` 0–9.
  - `s_lower` 0–9, then `s_higher` 0–5.
  - `min_lower` 0–9, then `min_higher` 0–5.
  - Each digit carries into the next only when it is at its maximum and wraps to 0.
- Full wrap: a tick at 59:59.99 produces 00:00.00 and sets `overflow`. Counting continues.
- Digit outputs show the snapshot in LAP and the live digits otherwise. Counting continues while the display is frozen.
- Digits never hold a value above 9, or above 5 for the `_higher` digits of seconds and minutes.

## Timing
- All state is registered. Outputs are driven directly from registers or a 2:1 mux of registers, with no combinational path from any input.
- Pulse-to-state latency: a pulse sampled at edge E changes state and `running` at E.
- Start to first count: a start at edge E gives `ms_lower`=1 at edge E+DIVIDER.
- Tick period is exactly DIVIDER cycles with no drift. A stop/resume loses or gains no cycles.
- Entering LAP at edge E: the snapshot equals the live value just before E. If a tick also occurs at E, the pre-tick value is captured.
- Reset asserted mid-count: all outputs go to reset values immediately, asynchronously. Release is synchronised by the surrounding reset logic.

## Configuration
- `STOPWATCH_LAP_EN` defined: LAP state, snapshot registers and `lap_active` behave as described above.
- Undefined:
  - `lap` input is ignored and the LAP state is not built.
  - `lap_active` is tied to 0.
  - Digit outputs always show the live digits.
  - All other behaviour is unchanged.

## Test plan
All scenarios use DIVIDER=4 and COUNTER_WIDTH=3.
- Reset, then `start_stop` at edge 0 → `ms_lower`=1 at edge 4 and `ms_higher`=1, `ms_lower`=0 at edge 40; `running`=1 from edge 0.
- Run 400 cycles, pulse `start_stop`, wait 100 cycles, pulse again → display holds 01.00 while stopped; next tick arrives with the held prescaler phase preserved, with no lost cycles.
- Run to 00:03.27, pulse `lap` → display frozen at 00:03.27 and `lap_active`=1 for 80 cycles; pulse `lap` → display shows 00:03.47.
- Run 1,440,000 cycles from start → display 00:00.00, `overflow`=1; `clear` → `overflow`=0, IDLE, all digits 0.
- `clear`, `start_stop` and `lap` in the same cycle while RUNNING → IDLE with digits 0. `start_stop` and `lap` together → STOPPED with `lap_active`=0.
- Assert `reset_n`=0 mid-run at 00:12.34 → all digits 0, `running`=0 and `overflow`=0 without waiting for a clock edge.
